// File: rtl/apb_read_master.sv
// apb_read_master
//   APB read initiator for the flash-controller bring-up path. Accepts one read
//   request at a time, drives a free-running divided APB clock (pclk), runs a
//   SETUP phase followed by an ACCESS phase that ends on pready or on timeout,
//   and returns a single-cycle response.
//
//   Handshake: a request transfers in any clk cycle where req_valid and
//   req_ready are both high; req_addr is captured then and later changes are
//   ignored. The response has no backpressure: rsp_valid is high for exactly
//   one clk cycle and rsp_data/rsp_err hold until the next response.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   req_valid/req_ready request handshake, req_addr byte address
//   rsp_valid/rsp_data/rsp_err  response pulse, read data (0 on error), timeout flag
//   pclk, psel, penable, pwrite, paddr  APB initiator outputs (all registered)
//   pready, prdata      APB responder inputs
module apb_read_master #(
  parameter int CLK_DIV = 2,     // clk cycles per pclk half-period, 1..255
  parameter int TIMEOUT = 255    // ACCESS pclk rises allowed without pready, 1..65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        pclk,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  input  logic        pready,
  input  logic [31:0] prdata
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    SETUP     = 2'd2,
    ACCESS    = 2'd3
  } state_t;

  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  div_cnt;
  logic [15:0] tmo_cnt;
  logic [31:0] addr_q;
  logic        pclk_rise;

  // pclk is about to go 0->1 at the end of this clk cycle. Every APB output
  // changes only on this strobe so the responder sees them stable at the
  // following pclk fall.
  assign pclk_rise = (div_cnt == DIV_LAST) && !pclk;

  assign req_ready = (state == IDLE);

  // Free-running clock divider.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= 8'd0;
      pclk    <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= 8'd0;
      pclk    <= ~pclk;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

  // Transfer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= 32'd0;
      tmo_cnt   <= 16'd0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      pwrite    <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q <= req_addr;
            state  <= WAIT_EDGE;
          end
        end
        WAIT_EDGE: begin
          if (pclk_rise) begin
            psel    <= 1'b1;
            penable <= 1'b0;
            paddr   <= addr_q;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (pclk_rise) begin
            penable <= 1'b1;
            tmo_cnt <= 16'd0;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (pclk_rise) begin
            // pready is tested first so a reply on the last allowed rise
            // still counts as a success.
            if (pready) begin
              rsp_data  <= prdata;
              rsp_err   <= 1'b0;
              rsp_valid <= 1'b1;
              psel      <= 1'b0;
              penable   <= 1'b0;
              state     <= IDLE;
            end else if (tmo_cnt == TMO_LAST) begin
              rsp_data  <= 32'd0;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              psel      <= 1'b0;
              penable   <= 1'b0;
              state     <= IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_read_master.sv
// Directed bench for apb_read_master: main instance with CLK_DIV=2, TIMEOUT=8
// and a second instance with TIMEOUT=4 for the pready-at-timeout boundary.
module tb_apb_read_master;

  logic        clk = 1'b0;
  logic        rst;

  logic        req_valid, req_ready, rsp_valid, rsp_err;
  logic [31:0] req_addr, rsp_data, paddr, prdata;
  logic        pclk, psel, penable, pwrite, pready;

  logic        t4_req_valid, t4_req_ready, t4_rsp_valid, t4_rsp_err;
  logic [31:0] t4_req_addr, t4_rsp_data, t4_paddr, t4_prdata;
  logic        t4_pclk, t4_psel, t4_penable, t4_pwrite, t4_pready;

  int vectors = 0;
  int miscompares = 0;

  apb_read_master #(.CLK_DIV(2), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .pclk(pclk), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pready(pready), .prdata(prdata)
  );

  apb_read_master #(.CLK_DIV(2), .TIMEOUT(4)) dut4 (
    .clk(clk), .rst(rst),
    .req_valid(t4_req_valid), .req_ready(t4_req_ready), .req_addr(t4_req_addr),
    .rsp_valid(t4_rsp_valid), .rsp_data(t4_rsp_data), .rsp_err(t4_rsp_err),
    .pclk(t4_pclk), .psel(t4_psel), .penable(t4_penable), .pwrite(t4_pwrite),
    .paddr(t4_paddr), .pready(t4_pready), .prdata(t4_prdata)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic sig_of(input bit u, input int sel);
    case (sel)
      0:       return u ? t4_pclk : pclk;
      1:       return u ? t4_psel : psel;
      2:       return u ? t4_penable : penable;
      default: return u ? t4_rsp_valid : rsp_valid;
    endcase
  endfunction

  // Advance to the clk edge where pclk goes 0->1 (one pclk rise).
  task automatic wait_rise(input bit u, input string tag);
    logic prev;
    bit   hit;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      prev = sig_of(u, 0);
      tick();
      if (!prev && sig_of(u, 0)) hit = 1'b1;
    end
    check({tag, " pclk rise"}, 32'(hit), 32'd1);
  endtask

  // Bounded wait for psel (1), penable (2) or rsp_valid (3) to go high.
  task automatic wait_for(input bit u, input int sel, input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      tick();
      if (sig_of(u, sel)) hit = 1'b1;
    end
    check({tag, " wait"}, 32'(hit), 32'd1);
  endtask

  initial begin : stim
    logic [5:0] pclk_pat;
    bit         seen;
    bit         hit;

    rst = 1'b1;
    req_valid = 1'b0; req_addr = 32'd0; pready = 1'b0; prdata = 32'd0;
    t4_req_valid = 1'b0; t4_req_addr = 32'd0; t4_pready = 1'b0; t4_prdata = 32'd0;

    // 1: reset state and pclk cadence
    repeat (3) tick();
    rst = 1'b0;
    check("rst pclk", 32'(pclk), 32'd0);
    check("rst psel", 32'(psel), 32'd0);
    check("rst penable", 32'(penable), 32'd0);
    check("rst pwrite", 32'(pwrite), 32'd0);
    check("rst paddr", paddr, 32'd0);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst rsp_data", rsp_data, 32'd0);
    check("rst rsp_err", 32'(rsp_err), 32'd0);
    check("rst req_ready", 32'(req_ready), 32'd1);
    pclk_pat = 6'b100110;  // pclk after successive clk edges: 0,1,1,0,0,1
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("pclk cadence %0d", i), 32'(pclk), 32'(pclk_pat[i]));
    end

    // 2: normal read, pready at 3rd ACCESS rise
    req_valid = 1'b1; req_addr = 32'h0000_1234;
    tick();
    check("t2 req_ready after accept", 32'(req_ready), 32'd0);
    req_valid = 1'b0; req_addr = 32'hDEAD_BEEF;
    wait_for(0, 1, "t2 psel");
    check("t2 setup paddr", paddr, 32'h0000_1234);
    check("t2 setup penable", 32'(penable), 32'd0);
    wait_for(0, 2, "t2 penable");
    check("t2 access psel", 32'(psel), 32'd1);
    check("t2 access paddr", paddr, 32'h0000_1234);
    wait_rise(0, "t2 r1");
    check("t2 r1 rsp_valid", 32'(rsp_valid), 32'd0);
    wait_rise(0, "t2 r2");
    check("t2 r2 rsp_valid", 32'(rsp_valid), 32'd0);
    pready = 1'b1; prdata = 32'hA5A5_5A5A;
    wait_rise(0, "t2 r3");
    check("t2 rsp_valid", 32'(rsp_valid), 32'd1);
    check("t2 rsp_data", rsp_data, 32'hA5A5_5A5A);
    check("t2 rsp_err", 32'(rsp_err), 32'd0);
    check("t2 psel low", 32'(psel), 32'd0);
    check("t2 penable low", 32'(penable), 32'd0);
    pready = 1'b0; prdata = 32'd0;
    tick();
    check("t2 rsp_valid one cycle", 32'(rsp_valid), 32'd0);
    check("t2 rsp_data held", rsp_data, 32'hA5A5_5A5A);
    check("t2 paddr held", paddr, 32'h0000_1234);

    // 3: silent responder, timeout after 8 ACCESS rises
    req_valid = 1'b1; req_addr = 32'h0100_0000;
    tick();
    req_valid = 1'b0;
    wait_for(0, 2, "t3 penable");
    check("t3 paddr", paddr, 32'h0100_0000);
    for (int i = 1; i <= 7; i++) begin
      wait_rise(0, "t3 rise");
      check($sformatf("t3 r%0d rsp_valid", i), 32'(rsp_valid), 32'd0);
    end
    check("t3 rsp_data held before timeout", rsp_data, 32'hA5A5_5A5A);
    wait_rise(0, "t3 r8");
    check("t3 rsp_valid", 32'(rsp_valid), 32'd1);
    check("t3 rsp_err", 32'(rsp_err), 32'd1);
    check("t3 rsp_data", rsp_data, 32'd0);
    check("t3 psel low", 32'(psel), 32'd0);
    check("t3 penable low", 32'(penable), 32'd0);
    tick();
    check("t3 rsp_err held", 32'(rsp_err), 32'd1);

    // 4: second request held during first; pready high early (ignored
    // outside ACCESS) so each read ends at its first ACCESS rise
    pready = 1'b1; prdata = 32'h1111_2222;
    req_valid = 1'b1; req_addr = 32'h0000_0020;
    tick();
    req_addr = 32'h0000_0010;
    wait_for(0, 1, "t4 psel");
    check("t4 first paddr", paddr, 32'h0000_0020);
    check("t4 no early rsp", 32'(rsp_valid), 32'd0);
    wait_for(0, 2, "t4 penable");
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      tick();
      if (rsp_valid) hit = 1'b1;
      else check("t4 req_ready busy", 32'(req_ready), 32'd0);
    end
    check("t4 first rsp seen", 32'(hit), 32'd1);
    check("t4 first rsp_data", rsp_data, 32'h1111_2222);
    check("t4 req_ready with rsp", 32'(req_ready), 32'd1);
    tick();
    check("t4 second accepted", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    tick();
    tick();
    check("t4 idle pclk rise gap psel", 32'(psel), 32'd0);
    tick();
    check("t4 second psel", 32'(psel), 32'd1);
    check("t4 second paddr", paddr, 32'h0000_0010);
    prdata = 32'h3333_4444;
    wait_for(0, 3, "t4 second rsp");
    check("t4 second rsp_data", rsp_data, 32'h3333_4444);
    check("t4 second rsp_err", 32'(rsp_err), 32'd0);
    pready = 1'b0; prdata = 32'd0;

    // 5: TIMEOUT=4, pready exactly on the 4th ACCESS rise
    t4_req_valid = 1'b1; t4_req_addr = 32'h0000_0300;
    tick();
    t4_req_valid = 1'b0;
    wait_for(1, 2, "t5 penable");
    for (int i = 1; i <= 3; i++) begin
      wait_rise(1, "t5 rise");
      check($sformatf("t5 r%0d rsp_valid", i), 32'(t4_rsp_valid), 32'd0);
    end
    t4_pready = 1'b1; t4_prdata = 32'h5EED_0004;
    wait_rise(1, "t5 r4");
    check("t5 rsp_valid", 32'(t4_rsp_valid), 32'd1);
    check("t5 rsp_err", 32'(t4_rsp_err), 32'd0);
    check("t5 rsp_data", t4_rsp_data, 32'h5EED_0004);
    t4_pready = 1'b0; t4_prdata = 32'd0;

    // 6: reset during ACCESS, then a fresh read
    req_valid = 1'b1; req_addr = 32'h0000_0044;
    tick();
    req_valid = 1'b0;
    wait_for(0, 2, "t6 penable");
    wait_rise(0, "t6 r1");
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6 psel", 32'(psel), 32'd0);
    check("t6 penable", 32'(penable), 32'd0);
    check("t6 pclk", 32'(pclk), 32'd0);
    check("t6 rsp_valid", 32'(rsp_valid), 32'd0);
    check("t6 req_ready", 32'(req_ready), 32'd1);
    pready = 1'b1; prdata = 32'hFFFF_FFFF;
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    check("t6 no rsp after abort", 32'(seen), 32'd0);
    prdata = 32'hCAFE_F00D;
    req_valid = 1'b1; req_addr = 32'h0000_0080;
    tick();
    req_valid = 1'b0;
    wait_for(0, 1, "t6 fresh psel");
    check("t6 fresh paddr", paddr, 32'h0000_0080);
    wait_for(0, 3, "t6 fresh rsp");
    check("t6 fresh rsp_data", rsp_data, 32'hCAFE_F00D);
    check("t6 fresh rsp_err", 32'(rsp_err), 32'd0);
    pready = 1'b0;
    tick();

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
